// File: rtl/regseq_pkg.sv
//------------------------------------------------------------------------------
// regseq_pkg : shared widths, instruction field offsets, opcodes, FSM states
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regseq_pkg;

  localparam int OPW  = 4;
  localparam int IDXW = 4;
  localparam int DW   = 8;
  localparam int IW   = 24;

  localparam int OP_LSB  = 20;
  localparam int RD_LSB  = 16;
  localparam int RA_LSB  = 12;
  localparam int RB_LSB  = 8;
  localparam int IMM_LSB = 0;

  localparam logic [OPW-1:0] OP_LOADI = 4'd0;
  localparam logic [OPW-1:0] OP_ADD   = 4'd1;
  localparam logic [OPW-1:0] OP_SUB   = 4'd2;
  localparam logic [OPW-1:0] OP_AND   = 4'd3;
  localparam logic [OPW-1:0] OP_OR    = 4'd4;
  localparam logic [OPW-1:0] OP_XOR   = 4'd5;
  localparam logic [OPW-1:0] OP_MOV   = 4'd6;
  localparam logic [OPW-1:0] OP_NOP   = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/regseq_alu.sv
//------------------------------------------------------------------------------
// regseq_alu : combinational ALU producing result, flags and write/legal info
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regseq_alu
  import regseq_pkg::*;
(
  input  logic [OPW-1:0] i_op,
  input  logic [DW-1:0]  i_opA,
  input  logic [DW-1:0]  i_opB,
  input  logic [DW-1:0]  i_imm,
  output logic [DW-1:0]  o_result,
  output logic           o_carry,
  output logic           o_zero,
  output logic           o_legal,
  output logic           o_write
);

  logic [DW:0] w_sum;
  logic [DW:0] w_diff;

  assign w_sum  = {1'b0, i_opA} + {1'b0, i_opB};
  // The MSB of the 9-bit difference is set exactly when opA < opB (borrow).
  assign w_diff = {1'b0, i_opA} - {1'b0, i_opB};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    o_legal  = 1'b1;
    o_write  = 1'b1;
    case (i_op)
      OP_LOADI: o_result = i_imm;
      OP_ADD:   {o_carry, o_result} = w_sum;
      OP_SUB:   {o_carry, o_result} = w_diff;
      OP_AND:   o_result = i_opA & i_opB;
      OP_OR:    o_result = i_opA | i_opB;
      OP_XOR:   o_result = i_opA ^ i_opB;
      OP_MOV:   o_result = i_opA;
      OP_NOP:   o_write  = 1'b0;
      default: begin
        o_legal = 1'b0;
        o_write = 1'b0;
      end
    endcase
    o_zero = (o_result == '0);
  end

endmodule

`default_nettype wire

// File: rtl/regfile_sequencer.sv
//------------------------------------------------------------------------------
// regfile_sequencer : 4-cycle IDLE/READ/EXEC/WB instruction sequencer
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_sequencer
  import regseq_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [IW-1:0]   instr,
  output logic [IDXW-1:0] A_sel,
  output logic [IDXW-1:0] B_sel,
  input  logic [DW-1:0]   A,
  input  logic [DW-1:0]   B,
  output logic [IDXW-1:0] replaceSel,
  output logic [DW-1:0]   replaceData,
  output logic            replaceEn,
  output logic            done,
  output logic            err,
  output logic            carry,
  output logic            zero
);

  state_e          r_state;
  state_e          w_nextState;
  logic [OPW-1:0]  r_op;
  logic [IDXW-1:0] r_rd;
  logic [DW-1:0]   r_imm;
  logic [IDXW-1:0] r_aSel;
  logic [IDXW-1:0] r_bSel;
  logic [DW-1:0]   r_opA;
  logic [DW-1:0]   r_opB;
  logic [DW-1:0]   r_result;
  logic [IDXW-1:0] r_replaceSel;
  logic            r_wen;
  logic            r_done;
  logic            r_err;
  logic            r_carry;
  logic            r_zero;

  logic            w_accept;
  logic [DW-1:0]   w_aluResult;
  logic            w_aluCarry;
  logic            w_aluZero;
  logic            w_aluLegal;
  logic            w_aluWrite;

  assign instr_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept    = instr_valid & instr_ready;

  regseq_alu u_alu (
    .i_op     (r_op),
    .i_opA    (r_opA),
    .i_opB    (r_opB),
    .i_imm    (r_imm),
    .o_result (w_aluResult),
    .o_carry  (w_aluCarry),
    .o_zero   (w_aluZero),
    .o_legal  (w_aluLegal),
    .o_write  (w_aluWrite)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_nextState = S_READ;
      S_READ:  w_nextState = S_EXEC;
      S_EXEC:  w_nextState = S_WB;
      S_WB:    w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= '0;
      r_rd         <= '0;
      r_imm        <= '0;
      r_aSel       <= '0;
      r_bSel       <= '0;
      r_opA        <= '0;
      r_opB        <= '0;
      r_result     <= '0;
      r_replaceSel <= '0;
      r_wen        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_carry      <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Read selects are loaded here so they are already valid throughout READ.
          if (w_accept) begin
            r_op   <= instr[OP_LSB  +: OPW];
            r_rd   <= instr[RD_LSB  +: IDXW];
            r_imm  <= instr[IMM_LSB +: DW];
            r_aSel <= instr[RA_LSB  +: IDXW];
            r_bSel <= instr[RB_LSB  +: IDXW];
          end
        end
        S_READ: begin
          r_opA <= A;
          r_opB <= B;
        end
        S_EXEC: begin
          r_result     <= w_aluResult;
          r_replaceSel <= r_rd;
          r_done       <= 1'b1;
          r_err        <= ~w_aluLegal;
          r_wen        <= w_aluWrite;
          if (w_aluWrite) begin
            r_carry <= w_aluCarry;
            r_zero  <= w_aluZero;
          end
        end
        default: ;
      endcase
    end
  end

  assign A_sel       = r_aSel;
  assign B_sel       = r_bSel;
  assign replaceSel  = r_replaceSel;
  assign replaceData = r_result;
  // A reset arriving during WB must suppress the write at that same edge.
  assign replaceEn   = r_wen & ~rst;
  assign done        = r_done & ~rst;
  assign err         = r_err & ~rst;
  assign carry       = r_carry;
  assign zero        = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
//------------------------------------------------------------------------------
// tb_regfile_sequencer : directed scenarios plus random traffic vs. a model
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [23:0] instr = '0;
  logic [3:0]  A_sel, B_sel, replaceSel;
  logic [7:0]  A, B, replaceData;
  logic        replaceEn, done, err, carry, zero;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .A_sel(A_sel), .B_sel(B_sel), .A(A), .B(B),
    .replaceSel(replaceSel), .replaceData(replaceData), .replaceEn(replaceEn),
    .done(done), .err(err), .carry(carry), .zero(zero)
  );

  // 16x8 register file driven by the sequencer's outputs
  logic [7:0] rf [16];
  logic       wrEn = 1'b0;
  logic [3:0] wrSel = '0;
  logic [7:0] wrData = '0;
  assign A = rf[A_sel];
  assign B = rf[B_sel];
  always @(negedge clk) begin
    wrEn   = replaceEn;
    wrSel  = replaceSel;
    wrData = replaceData;
  end
  always @(posedge clk) if (wrEn) rf[wrSel] <= wrData;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural registers, flags and a phase count since acceptance
  logic [7:0] mdl [16];
  int         phase = 0;
  logic [3:0] pRd = '0;
  logic [7:0] pRes = '0;
  bit         pWr = 0, pIll = 0, pC = 0;
  logic [3:0] eASel = '0, eBSel = '0;
  bit         mC = 0, mZ = 0;
  bit         justReset = 0;
  int         tRes;
  bit         tC, tW, tI;

  function automatic void aluModel(input int op, input int a, input int b, input int imm,
                                   output int res, output bit c, output bit wr, output bit ill);
    res = 0; c = 0; wr = 1; ill = 0;
    case (op)
      0: res = imm;
      1: begin res = (a + b) % 256; c = (a + b) > 255; end
      2: begin res = (a - b + 256) % 256; c = a < b; end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = a;
      7: wr = 0;
      default: begin wr = 0; ill = 1; end
    endcase
  endfunction

  always @(posedge clk) begin
    justReset = rst;
    if (rst) begin
      phase = 0; mC = 0; mZ = 0; eASel = '0; eBSel = '0;
    end else begin
      case (phase)
        0: if (instr_valid) begin
          aluModel(int'(instr[23:20]), int'(mdl[instr[15:12]]), int'(mdl[instr[11:8]]),
                   int'(instr[7:0]), tRes, tC, tW, tI);
          pRes = tRes[7:0]; pC = tC; pWr = tW; pIll = tI; pRd = instr[19:16];
          eASel = instr[15:12]; eBSel = instr[11:8];
          phase = 1;
        end
        1: phase = 2;
        2: begin
          phase = 3;
          if (pWr) begin mC = pC; mZ = (pRes == 8'h00); end
        end
        default: begin
          phase = 0;
          if (pWr) mdl[pRd] = pRes;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("instr_ready", instr_ready, (phase == 0) && !rst);
    check("done", done, (phase == 3) && !rst);
    check("err", err, (phase == 3) && pIll && !rst);
    check("replaceEn", replaceEn, (phase == 3) && pWr && !rst);
    check("A_sel", A_sel, eASel);
    check("B_sel", B_sel, eBSel);
    check("carry", carry, mC);
    check("zero", zero, mZ);
    if (justReset) begin
      check("rst_replaceSel", replaceSel, 0);
      check("rst_replaceData", replaceData, 0);
    end
    if ((phase == 3) && pWr && !rst) begin
      check("replaceSel", replaceSel, pRd);
      check("replaceData", replaceData, pRes);
    end
  end

  bit cntEn = 0;
  int readyCnt = 0;
  always @(negedge clk) if (cntEn && instr_ready) readyCnt++;

  function automatic logic [23:0] enc(input int op, input int rd, input int ra, input int rb, input int imm);
    logic [31:0] o, d, a, b, m;
    o = op; d = rd; a = ra; b = rb; m = imm;
    return {o[3:0], d[3:0], a[3:0], b[3:0], m[7:0]};
  endfunction

  task automatic settle();
    @(posedge clk); #1;
  endtask

  // Offer one instruction, wait for its done; lat = edges from acceptance to done cycle
  task automatic issue(input logic [23:0] ins, input bit keep, output int lat,
                       output bit sawErr, output bit sawWen);
    int n;
    int acc;
    instr = ins; instr_valid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!instr_ready && n < 20);
    if (!instr_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    acc = cyc;
    if (!keep) instr_valid = 1'b0;
    sawWen = 0; n = 0;
    do begin @(negedge clk); n++; if (replaceEn) sawWen = 1; end while (!done && n < 10);
    if (!done) check("done_timeout", 0, 1);
    lat = cyc - acc + 1;
    sawErr = err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit se, sw;
    logic [31:0] rv;
    for (int i = 0; i < 16; i++) begin
      rf[i] = 8'(i * 17);
      mdl[i] = 8'(i * 17);
    end
    repeat (3) settle();
    check("reset_ready_low", instr_ready, 0);
    rst = 1'b0;
    settle();

    issue(enc(0, 1, 0, 0, 8'hAA), 0, lat, se, sw);
    check("loadi1_latency", lat, 3);
    issue(enc(0, 2, 0, 0, 8'h55), 0, lat, se, sw);
    check("loadi2_latency", lat, 3);
    settle();
    check("r1_AA", rf[1], 8'hAA);
    check("r2_55", rf[2], 8'h55);
    check("loadi_zero", zero, 0);

    issue(enc(0, 1, 0, 0, 8'hF0), 0, lat, se, sw);
    issue(enc(0, 2, 0, 0, 8'h20), 0, lat, se, sw);
    issue(enc(1, 3, 1, 2, 0), 0, lat, se, sw);
    check("add_carry", carry, 1);
    check("add_zero", zero, 0);
    settle();
    check("r3_10", rf[3], 8'h10);
    issue(enc(2, 4, 2, 1, 0), 0, lat, se, sw);
    check("sub_borrow", carry, 1);
    settle();
    check("r4_30", rf[4], 8'h30);
    check("model_r4", mdl[4], 8'h30);

    issue(enc(0, 1, 0, 0, 8'hAA), 0, lat, se, sw);
    issue(enc(5, 5, 1, 1, 0), 0, lat, se, sw);
    check("xor_zero", zero, 1);
    check("xor_carry", carry, 0);
    settle();
    check("r5_00", rf[5], 8'h00);
    issue(enc(1, 1, 1, 1, 0), 0, lat, se, sw);
    check("addself_carry", carry, 1);
    settle();
    check("r1_54", rf[1], 8'h54);

    issue(enc(12, 1, 2, 3, 8'h99), 0, lat, se, sw);
    check("illegal_err_with_done", se, 1);
    check("illegal_no_write", sw, 0);
    check("illegal_latency", lat, 3);
    check("illegal_carry_kept", carry, 1);
    check("illegal_zero_kept", zero, 0);
    settle();
    check("illegal_r1_kept", rf[1], 8'h54);

    readyCnt = 0; cntEn = 1;
    issue(enc(0, 6, 0, 0, 8'h01), 1, lat, se, sw);
    issue(enc(1, 6, 6, 6, 0), 1, lat, se, sw);
    issue(enc(1, 6, 6, 6, 0), 0, lat, se, sw);
    cntEn = 0;
    check("held_valid_ready_cycles", readyCnt, 3);
    settle();
    check("r6_chain", rf[6], 8'h04);

    instr = enc(0, 7, 0, 0, 8'h3C); instr_valid = 1'b1;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!instr_ready && n < 20);
    end
    settle();
    instr_valid = 1'b0;
    settle();
    rst = 1'b1;
    settle();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", instr_ready, 1);
    check("postrst_done", done, 0);
    check("postrst_carry", carry, 0);
    check("postrst_zero", zero, 0);
    check("postrst_replaceData", replaceData, 0);
    repeat (4) settle();
    check("r7_unchanged", rf[7], 8'h77);

    for (int i = 0; i < 800; i++) begin
      settle();
      rv = $urandom;
      rv[23:20] = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      instr = rv[23:0];
      instr_valid = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 49) == 0);
    end
    settle();
    rst = 1'b0; instr_valid = 1'b0;
    repeat (6) settle();
    for (int i = 0; i < 16; i++) check("final_regfile", rf[i], mdl[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port instr_valid, input, 1 bit: instruction offered.
REQ-005 SHALL have port instr_ready, output, 1 bit: sequencer accepts an instruction this cycle.
REQ-006 SHALL have port instr, input, 24 bits, with fields [23:20] op, [19:16] rd, [15:12] ra, [11:8] rb, [7:0] imm.
REQ-007 SHALL have ports A_sel and B_sel, outputs, 4 bits each: register file read selects.
REQ-008 SHALL have ports A and B, inputs, 8 bits each: combinational register file read data.
REQ-009 SHALL have port replaceSel, output, 4 bits: write-back register index.
REQ-010 SHALL have port replaceData, output, 8 bits: write-back data.
REQ-011 SHALL have port replaceEn, output, 1 bit: write strobe, sampled by the register file at the rising clk edge.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1 bit: one-cycle illegal-opcode pulse.
REQ-014 SHALL have ports carry and zero, outputs, 1 bit each: flags of the last completed instruction.

Function
REQ-015 SHALL implement the FSM IDLE -> READ -> EXEC -> WB -> IDLE, with exactly one state per cycle and no stalls.
REQ-016 SHALL assert instr_ready only in IDLE with rst low; an instruction is accepted at a clk edge where instr_valid & instr_ready, instr is captured whole, and the FSM moves to READ.
REQ-017 SHALL ignore instr_valid when instr_ready is low, with no buffering.
REQ-018 SHALL, in READ, drive A_sel=ra and B_sel=rb, and at the end of the cycle latch A and B into operand registers.
REQ-019 SHALL hold A_sel and B_sel at their last value in all other states.
REQ-020 SHALL, in EXEC, compute the result from the latched operands and register the result and flags at the end of the cycle.
REQ-021 SHALL implement ops as follows: 0 LOADI = imm; 1 ADD = A+B; 2 SUB = A-B; 3 AND; 4 OR; 5 XOR; 6 MOV = A; 7 NOP = no write.
REQ-022 SHALL compute ADD and SUB in 9 bits, with an 8-bit result that wraps modulo 256, carry = bit 8 for ADD, and carry = borrow (A<B) for SUB.
REQ-023 SHALL clear carry for all other writing ops, and set zero = (result==0) for every writing op.
REQ-024 SHALL leave carry and zero unchanged for NOP and for illegal ops.
REQ-025 SHALL, in WB, drive replaceSel=rd and replaceData=result, holding both stable for the whole cycle, and set replaceEn=1 for ops 0-6 only.
REQ-026 SHALL pulse done high in the WB cycle for every accepted instruction, including NOP and illegal ops.
REQ-027 SHALL treat ops 8-15 as illegal: err pulses with done in WB, replaceEn stays 0, and the register file is unchanged.
REQ-028 SHALL complete in fixed latency: acceptance at edge N gives READ in cycle N+1, EXEC in N+2, and WB/done in N+3, with instr_ready high again in cycle N+4, for a throughput of one instruction per 4 cycles.
REQ-029 SHALL allow rd to equal ra and/or rb: operands are latched in READ, so the write in WB cannot corrupt them.
REQ-030 SHALL guarantee back-to-back read-after-write: the next instruction's READ occurs after the WB edge and sees the new value.
REQ-031 SHALL keep replaceEn at 0 in every cycle except WB.

Reset
REQ-032 SHALL, while rst is high at a clk edge, enter IDLE and clear the following to 0: A_sel, B_sel, replaceSel, replaceData, replaceEn, done, err, carry, zero, operand and result registers.
REQ-033 SHALL hold instr_ready at 0 during any cycle where rst is high.
REQ-034 SHALL, on reset during READ, EXEC or WB, abort the instruction: no write, no done, no err.
REQ-035 SHALL, on reset asserted in WB, drop replaceEn combinationally with rst, so that no write occurs at that edge.

Structure
REQ-036 SHALL place in package regseq_pkg: opcode constants, FSM state enum, field widths (OPW=4, IDXW=4, DW=8) and instr field offsets.
REQ-037 SHALL place the combinational ALU (op, A, B, imm -> result, carry, zero, legal, write) in sub-module regseq_alu, with FSM and registers in regfile_sequencer.

Verification
REQ-038 SHALL be verified by a bench that reuses the existing 16x8 register_file model driven by this block's outputs.
REQ-039 SHALL pass this scenario: LOADI r1,0xAA then LOADI r2,0x55 -> each done 3 cycles after acceptance; r1=0xAA, r2=0x55; zero=0.
REQ-040 SHALL pass this scenario: r1=0xF0, r2=0x20, ADD r3,r1,r2 -> r3=0x10, carry=1, zero=0; then SUB r4,r2,r1 -> r4=0x30, carry=1.
REQ-041 SHALL pass this scenario: XOR r5,r1,r1 with r1=0xAA -> r5=0x00, zero=1, carry=0; then ADD r1,r1,r1 -> r1=0x54, carry=1 (rd==ra).
REQ-042 SHALL pass this scenario: op=0xC with rd=r1 -> err and done pulse together, replaceEn never high, r1 unchanged, flags unchanged.
REQ-043 SHALL pass this scenario: instr_valid held high across 3 instructions -> instr_ready high exactly 1 cycle in 4, and later instructions read the prior results.
REQ-044 SHALL pass this scenario: rst pulsed during EXEC of LOADI r7,0x3C -> r7 unchanged, no done, all outputs 0, instr_ready=1 on the first cycle after rst falls.
